// File: rtl/flag_sequence_core.sv
// Semaphore memory-game core: LFSR flag sequence, show/play phases, score, lives, pause, quit.
// Define FLAG_SPEEDUP_EN to shorten the step period as the score rises.
module flag_sequence_core #(
    parameter int DIRW     = 2,
    parameter int TPERF    = 50000000,
    parameter int TICKW    = 26,
    parameter int MAXLIVES = 3,
    parameter int SCOREW   = 10
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic [15:0]            Rand,
    input  logic [(1<<DIRW)-1:0]   Buttons,
    input  logic                   Esc,
    input  logic                   Enter,
    output logic [SCOREW-1:0]      Score,
    output logic [2:0]             Lives,
    output logic                   Turn,
    output logic [DIRW-1:0]        ShowDir,
    output logic                   ShowOn,
    output logic                   Corpse,
    output logic [TICKW-1:0]       Ticks,
    output logic                   Quit
);

    localparam int NDIR = 1 << DIRW;

    typedef enum logic [2:0] {IDLE, SHOW, PLAY, PAUSE, DEAD, OVER} state_t;

    state_t             state;
    state_t             prior;
    logic [15:0]        seed;
    logic [15:0]        curr;
    logic [15:0]        lfsr_next;
    logic [15:0]        rand_seed;
    logic [DIRW-1:0]    fb;
    logic [SCOREW-1:0]  len;
    logic [SCOREW-1:0]  moves;
    logic [TICKW-1:0]   period;
    logic [TICKW-1:0]   last_tick;
    logic [TICKW-1:0]   gap;
    logic [NDIR-1:0]    btn_q;
    logic [NDIR-1:0]    btn_prev;
    logic [NDIR-1:0]    rise;
    logic [DIRW-1:0]    press_idx;
    logic               press;
    logic               hit;
    logic               timeout;
    logic [2:0]         lives_inc;

    assign rand_seed = (Rand == 16'h0000) ? 16'hACE1 : Rand;

    always_comb begin
        fb = '0;
        for (int i = 0; i < DIRW; i++)
            fb[i] = curr[i] ^ curr[i+1] ^ curr[i+4] ^ curr[i+6];
        lfsr_next = (curr >> DIRW) | (16'(fb) << (16 - DIRW));
    end

`ifdef FLAG_SPEEDUP_EN
    logic [3:0] level;
    assign level  = (Score > SCOREW'(15)) ? 4'd15 : Score[3:0];
    assign period = TICKW'(TPERF) - TICKW'(level) * TICKW'(TPERF >> 5);
`else
    assign period = TICKW'(TPERF);
`endif

    assign last_tick = period - TICKW'(1);
    assign gap       = period >> 2;

    // Buttons pass through one sync stage before edge detection
    assign rise = btn_q & ~btn_prev;
    assign press = $onehot(rise);

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NDIR; i++)
            if (rise[i])
                press_idx = DIRW'(i);
    end

    assign hit       = press && (press_idx == curr[DIRW-1:0]);
    assign timeout   = (ticks_ge_last());
    assign lives_inc = Lives + 3'd1;

    function automatic logic ticks_ge_last();
        return Ticks >= last_tick;
    endfunction

    assign ShowDir = curr[DIRW-1:0];
    assign ShowOn  = (state == SHOW) && (Ticks > gap);

    always_ff @(posedge Clock) begin
        if (Reset || !Enable) begin
            state    <= IDLE;
            prior    <= SHOW;
            seed     <= rand_seed;
            curr     <= rand_seed;
            len      <= '0;
            moves    <= '0;
            Score    <= '0;
            Lives    <= '0;
            Turn     <= 1'b0;
            Corpse   <= 1'b0;
            Ticks    <= '0;
            Quit     <= 1'b0;
            btn_q    <= '0;
            btn_prev <= '0;
        end else begin
            btn_q    <= Buttons;
            btn_prev <= btn_q;
            unique case (state)
                IDLE: begin
                    if (Esc)
                        Quit <= 1'b1;
                    else if (Enter) begin
                        state <= SHOW;
                        Ticks <= '0;
                    end
                end
                SHOW: begin
                    if (Esc) begin
                        state <= PAUSE;
                        prior <= SHOW;
                    end else if (timeout) begin
                        Ticks <= '0;
                        if (moves == len) begin
                            state <= PLAY;
                            Turn  <= 1'b1;
                            curr  <= seed;
                            moves <= '0;
                        end else begin
                            curr  <= lfsr_next;
                            moves <= moves + SCOREW'(1);
                        end
                    end else begin
                        Ticks <= Ticks + TICKW'(1);
                    end
                end
                PLAY: begin
                    if (Esc) begin
                        state <= PAUSE;
                        prior <= PLAY;
                    end else if (hit) begin
                        Ticks <= '0;
                        if (moves == len) begin
                            Score <= (Score == '1) ? Score : Score + SCOREW'(1);
                            len   <= (len == '1) ? len : len + SCOREW'(1);
                            curr  <= seed;
                            moves <= '0;
                            Turn  <= 1'b0;
                            state <= SHOW;
                        end else begin
                            curr  <= lfsr_next;
                            moves <= moves + SCOREW'(1);
                        end
                    end else if (press || timeout) begin
                        Lives  <= lives_inc;
                        len    <= '0;
                        moves  <= '0;
                        Turn   <= 1'b0;
                        Corpse <= 1'b1;
                        seed   <= rand_seed;
                        curr   <= rand_seed;
                        state  <= (lives_inc == 3'(MAXLIVES)) ? OVER : DEAD;
                    end else begin
                        Ticks <= Ticks + TICKW'(1);
                    end
                end
                PAUSE: begin
                    if (Esc)
                        Quit <= 1'b1;
                    else if (Enter)
                        state <= prior;
                end
                DEAD: begin
                    if (Esc)
                        Quit <= 1'b1;
                    else if (Enter) begin
                        Corpse <= 1'b0;
                        Ticks  <= '0;
                        state  <= SHOW;
                    end
                end
                OVER: begin
                    if (Esc || Enter)
                        Quit <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_sequence_core.sv
// Directed scoreboard bench for flag_sequence_core with a short step period.
module tb_flag_sequence_core;

    localparam int DIRW  = 2;
    localparam int TICKW = 8;

    localparam int S_SCORE  = 0;
    localparam int S_LIVES  = 1;
    localparam int S_TURN   = 2;
    localparam int S_DIR    = 3;
    localparam int S_ON     = 4;
    localparam int S_CORPSE = 5;
    localparam int S_TICKS  = 6;
    localparam int S_QUIT   = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [15:0]      rand_val;
    logic [3:0]       buttons;
    logic             esc;
    logic             enter;
    logic [9:0]       score;
    logic [2:0]       lives;
    logic             turn;
    logic [DIRW-1:0]  show_dir;
    logic             show_on;
    logic             corpse;
    logic [TICKW-1:0] ticks;
    logic             quit;
    logic             done = 1'b0;

    flag_sequence_core #(
        .DIRW(DIRW), .TPERF(16), .TICKW(TICKW), .MAXLIVES(3), .SCOREW(10)
    ) dut (
        .Clock(clk), .Reset(reset), .Enable(enable), .Rand(rand_val),
        .Buttons(buttons), .Esc(esc), .Enter(enter),
        .Score(score), .Lives(lives), .Turn(turn), .ShowDir(show_dir),
        .ShowOn(show_on), .Corpse(corpse), .Ticks(ticks), .Quit(quit)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    function automatic int sample(int sel);
        case (sel)
            S_SCORE:  return int'(score);
            S_LIVES:  return int'(lives);
            S_TURN:   return int'(turn);
            S_DIR:    return int'(show_dir);
            S_ON:     return int'(show_on);
            S_CORPSE: return int'(corpse);
            S_TICKS:  return int'(ticks);
            default:  return int'(quit);
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            int   act;
            e   = q.pop_front();
            act = sample(e.sel);
            total++;
            if (act == e.val)
                passed++;
            else
                $display("FAIL %s: got %0d expected %0d", e.tag, act, e.val);
        end
    end

    task automatic chk(string tag, int sel, int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        step(1);
        enter = 1'b0;
    endtask

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: wait expired before end of test");
            $finish;
        end
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        rand_val = 16'h1234;
        buttons  = 4'b0000;
        esc      = 1'b0;
        enter    = 1'b0;
        step(2);
        reset = 1'b0;
        total++;
        if (score === 10'd0 && lives === 3'd0 && turn === 1'b0 &&
            show_on === 1'b0 && corpse === 1'b0 && ticks === '0 &&
            quit === 1'b0)
            passed++;
        else
            $display("FAIL rst_direct: s=%0d l=%0d t=%0d on=%0d c=%0d k=%0d q=%0d",
                     score, lives, turn, show_on, corpse, ticks, quit);
        chk("rst_score", S_SCORE, 0);
        chk("rst_lives", S_LIVES, 0);
        chk("rst_turn", S_TURN, 0);
        chk("rst_on", S_ON, 0);
        chk("rst_corpse", S_CORPSE, 0);
        chk("rst_ticks", S_TICKS, 0);
        chk("rst_quit", S_QUIT, 0);
        chk("rst_dir", S_DIR, 0);

        pulse_enter();
        chk("show_t0", S_TICKS, 0);
        chk("show_on_t0", S_ON, 0);
        step(4);
        chk("show_t4", S_TICKS, 4);
        chk("show_on_t4", S_ON, 0);
        step(1);
        chk("show_on_t5", S_ON, 1);
        step(10);
        chk("show_t15", S_TICKS, 15);
        chk("show_turn15", S_TURN, 0);
        step(1);
        chk("play_turn", S_TURN, 1);
        chk("play_t0", S_TICKS, 0);
        chk("play_dir", S_DIR, 0);
        chk("play_on", S_ON, 0);

        buttons = 4'b0001;
        step(1);
        chk("lat_score0", S_SCORE, 0);
        chk("lat_ticks1", S_TICKS, 1);
        step(1);
        chk("hit_score1", S_SCORE, 1);
        chk("hit_turn0", S_TURN, 0);
        chk("hit_ticks0", S_TICKS, 0);
        chk("hit_dir_seed", S_DIR, 0);
        buttons = 4'b0000;

        step(16);
        chk("len1_dir2", S_DIR, 1);
        chk("len1_turn", S_TURN, 0);
        step(16);
        chk("len1_play", S_TURN, 1);
        chk("len1_dir1", S_DIR, 0);

        buttons = 4'b0001;
        step(2);
        chk("seq_adv_dir", S_DIR, 1);
        chk("seq_adv_turn", S_TURN, 1);
        chk("seq_adv_score", S_SCORE, 1);
        buttons = 4'b0000;
        step(2);
        buttons = 4'b0010;
        step(2);
        chk("seq_done_score", S_SCORE, 2);
        chk("seq_done_turn", S_TURN, 0);
        buttons  = 4'b0000;
        rand_val = 16'h0000;

        step(48);
        chk("len2_play", S_TURN, 1);
        chk("len2_dir", S_DIR, 0);
        buttons = 4'b0011;
        step(2);
        chk("multi_lives", S_LIVES, 0);
        chk("multi_turn", S_TURN, 1);
        chk("multi_ticks", S_TICKS, 2);
        buttons = 4'b0000;
        step(2);
        buttons = 4'b0010;
        step(2);
        chk("miss_lives", S_LIVES, 1);
        chk("miss_corpse", S_CORPSE, 1);
        chk("miss_turn", S_TURN, 0);
        chk("miss_score", S_SCORE, 2);
        chk("miss_seed_ace1", S_DIR, 1);
        buttons = 4'b0000;
        step(5);
        chk("dead_corpse", S_CORPSE, 1);
        chk("dead_lives", S_LIVES, 1);

        pulse_enter();
        chk("cont_corpse", S_CORPSE, 0);
        chk("cont_ticks", S_TICKS, 0);
        chk("cont_dir", S_DIR, 1);
        step(16);
        chk("cont_play", S_TURN, 1);
        step(15);
        chk("to_t15", S_TICKS, 15);
        chk("to_lives1", S_LIVES, 1);
        step(1);
        chk("to_lives2", S_LIVES, 2);
        chk("to_corpse", S_CORPSE, 1);
        chk("to_turn", S_TURN, 0);
        pulse_enter();
        step(16);
        chk("to2_play", S_TURN, 1);
        step(16);
        chk("over_lives", S_LIVES, 3);
        chk("over_corpse", S_CORPSE, 1);
        step(3);
        chk("over_corpse_held", S_CORPSE, 1);
        chk("over_noquit", S_QUIT, 0);
        pulse_enter();
        chk("over_quit", S_QUIT, 1);

        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst2_quit", S_QUIT, 0);
        chk("rst2_lives", S_LIVES, 0);
        chk("rst2_score", S_SCORE, 0);
        chk("rst2_corpse", S_CORPSE, 0);
        chk("rst2_dir_ace1", S_DIR, 1);

        rand_val = 16'h1234;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst3_dir", S_DIR, 0);
        pulse_enter();
        step(16);
        chk("p_play", S_TURN, 1);
        step(7);
        chk("p_t7", S_TICKS, 7);
        esc = 1'b1;
        step(1);
        esc = 1'b0;
        chk("p_frozen0", S_TICKS, 7);
        step(100);
        chk("p_frozen100", S_TICKS, 7);
        chk("p_lives", S_LIVES, 0);
        chk("p_turn", S_TURN, 1);
        pulse_enter();
        chk("p_resume", S_TICKS, 7);
        step(1);
        chk("p_run", S_TICKS, 8);
        esc = 1'b1;
        step(1);
        chk("p_esc1", S_QUIT, 0);
        step(1);
        chk("p_esc2", S_QUIT, 1);
        esc = 1'b0;

        enable = 1'b0;
        step(1);
        chk("dis_quit", S_QUIT, 0);
        chk("dis_ticks", S_TICKS, 0);
        chk("dis_turn", S_TURN, 0);
        enable = 1'b1;
        esc = 1'b1;
        step(1);
        esc = 1'b0;
        chk("idle_esc_quit", S_QUIT, 1);

        @(negedge clk);
        #1;
        done = 1'b1;
        if (passed != total)
            $display("FAIL summary: %0d of %0d checks failed", total - passed, total);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
